nodes_cache_ctrl: RTL and testbench

- Sequencing controller that shares one `nodes_cache` port among NUM_REQ A* requesters (expander, open-list, closed-list, path walker).
- Arbitrates requests round-robin, runs the cache lookup, and refills the cache from backing node memory on a read miss.
- Makes every write write-through to node memory.
- Sits between the A* engines and the `nodes_cache` / node-memory pair; one transaction is in flight at a time.

---
 rtl/node_mem.sv | 8 +
 rtl/nodes_cache_pkg.sv | 28 ++
 rtl/nodes_cache_ctrl_rr_arbiter.sv | 30 +++
 rtl/nodes_cache_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_nodes_cache_ctrl.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/node_mem.sv
// Node record type shared by the node memory, nodes_cache and the cache controller.
package node_mem_pkg;

  localparam int unsigned NODE_W = 32;

  typedef logic [NODE_W-1:0] node_mem_t;

endpackage

// File: rtl/nodes_cache_pkg.sv
// Shared types for the nodes_cache controller: FSM states, latched request record, stat width.
package nodes_cache_pkg;

  import node_mem_pkg::*;

  localparam int unsigned STAT_W       = 16;
  localparam int unsigned NODE_ADDR_W  = 10;
  localparam int unsigned REQ_ID_MAX_W = 3;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StCheck,
    StMemRd,
    StMemWr,
    StFill,
    StResp
  } ctrl_state_e;

  // Fields sized for the largest supported configuration (1k nodes, 8 requesters).
  typedef struct packed {
    logic [NODE_ADDR_W-1:0]  addr;
    logic                    write;
    node_mem_t               data;
    logic [REQ_ID_MAX_W-1:0] id;
  } ctrl_req_t;

endpackage

// File: rtl/nodes_cache_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester at or above rr_ptr, with wrap.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);

  logic [ID_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((32'(rr_ptr) + 32'(i)) % NUM_REQ);
      if (!grant_any && valid[cand]) begin
        grant     = NUM_REQ'(1) << cand;
        grant_idx = cand;
        grant_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nodes_cache_ctrl.sv
// Shares one nodes_cache port among NUM_REQ A* requesters, refilling on read miss, write-through.
// Optional hit/miss counters when NODES_CACHE_CTRL_STATS_EN is defined.
module nodes_cache_ctrl
  import node_mem_pkg::*, nodes_cache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned REQ_ID_W   = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ-1:0]                  req_write,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr,
  input  node_mem_t [NUM_REQ-1:0]             req_data,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output node_mem_t                           rsp_data,
  output logic                                cache_valid,
  output logic                                cache_write,
  output logic [ADDR_WIDTH-1:0]               cache_addr,
  output node_mem_t                           cache_wdata,
  input  logic                                cache_hit,
  input  node_mem_t                           cache_rdata,
  output logic                                mem_req,
  output logic                                mem_we,
  output logic [ADDR_WIDTH-1:0]               mem_addr,
  output node_mem_t                           mem_wdata,
  input  logic                                mem_ack,
  input  node_mem_t                           mem_rdata,
  output logic                                busy
`ifdef NODES_CACHE_CTRL_STATS_EN
  ,
  output logic [STAT_W-1:0]                   stat_hits,
  output logic [STAT_W-1:0]                   stat_misses
`endif
);

  ctrl_state_e           state_q, state_d;
  ctrl_req_t             req_q, req_d;
  logic [REQ_ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  node_mem_t             fill_q, fill_d;
  node_mem_t             rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0]    arb_valid;
  logic [NUM_REQ-1:0]    arb_grant;
  logic [REQ_ID_W-1:0]   arb_idx;
  logic                  arb_any;

  // No grant while reset is held, so req_ready stays low during reset.
  assign arb_valid = req_valid & {NUM_REQ{~rst}};

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (REQ_ID_W)
  ) u_arb (
    .valid     (arb_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_any (arb_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      req_q      <= '0;
      rr_ptr_q   <= '0;
      fill_q     <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      rr_ptr_q   <= rr_ptr_d;
      fill_q     <= fill_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    rr_ptr_d    = rr_ptr_q;
    fill_d      = fill_q;
    rsp_data_d  = rsp_data_q;
    req_ready   = '0;
    cache_valid = 1'b0;
    cache_write = 1'b0;
    cache_addr  = '0;
    cache_wdata = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;

    unique case (state_q)
      StIdle: begin
        if (arb_any) begin
          req_ready  = arb_grant;
          req_d.addr  = NODE_ADDR_W'(req_addr[arb_idx]);
          req_d.write = req_write[arb_idx];
          req_d.data  = req_data[arb_idx];
          req_d.id    = REQ_ID_MAX_W'(arb_idx);
          rr_ptr_d   = (arb_idx == REQ_ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
          state_d    = StLookup;
        end
      end
      StLookup: begin
        cache_valid = 1'b1;
        cache_addr  = ADDR_WIDTH'(req_q.addr);
        state_d     = StCheck;
      end
      StCheck: begin
        if (req_q.write) begin
          state_d = StMemWr;
        end else if (cache_hit) begin
          rsp_data_d = cache_rdata;
          state_d    = StResp;
        end else begin
          state_d = StMemRd;
        end
      end
      StMemRd: begin
        mem_req  = 1'b1;
        mem_addr = ADDR_WIDTH'(req_q.addr);
        if (mem_ack) begin
          fill_d  = mem_rdata;
          state_d = StFill;
        end
      end
      StMemWr: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ADDR_WIDTH'(req_q.addr);
        mem_wdata = req_q.data;
        if (mem_ack) begin
          state_d = StFill;
        end
      end
      StFill: begin
        // Writes also fill, which overwrites a stale line on a write hit.
        cache_valid = 1'b1;
        cache_write = 1'b1;
        cache_addr  = ADDR_WIDTH'(req_q.addr);
        cache_wdata = req_q.write ? req_q.data : fill_q;
        if (!req_q.write) begin
          rsp_data_d = fill_q;
        end
        state_d = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign rsp_valid = NUM_REQ'(state_q == StResp) << req_q.id;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != StIdle);

`ifdef NODES_CACHE_CTRL_STATS_EN
  logic hit_evt, miss_evt;

  assign hit_evt  = (state_q == StCheck) && !req_q.write && cache_hit;
  assign miss_evt = (state_q == StCheck) && !req_q.write && !cache_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else begin
      if (hit_evt && (stat_hits != '1)) begin
        stat_hits <= stat_hits + 1'b1;
      end
      if (miss_evt && (stat_misses != '1)) begin
        stat_misses <= stat_misses + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_nodes_cache_ctrl.sv
// Self-checking bench for nodes_cache_ctrl: transaction-level model plus directed scenarios.
module tb_nodes_cache_ctrl;
  import node_mem_pkg::*;

  localparam int NR = 4;
  localparam int IW = 2;
  localparam int AW = 10;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NR-1:0]           req_valid, req_ready, req_write, rsp_valid;
  logic [NR-1:0][AW-1:0]   req_addr;
  node_mem_t [NR-1:0]      req_data;
  node_mem_t               rsp_data, cache_wdata, cache_rdata, mem_wdata, mem_rdata;
  logic                    cache_valid, cache_write, cache_hit;
  logic [AW-1:0]           cache_addr, mem_addr;
  logic                    mem_req, mem_we, mem_ack, busy;
`ifdef NODES_CACHE_CTRL_STATS_EN
  logic [15:0]             stat_hits, stat_misses;
`endif

  nodes_cache_ctrl #(
    .ADDR_WIDTH (AW),
    .NUM_REQ    (NR),
    .REQ_ID_W   (IW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .cache_valid (cache_valid),
    .cache_write (cache_write),
    .cache_addr  (cache_addr),
    .cache_wdata (cache_wdata),
    .cache_hit   (cache_hit),
    .cache_rdata (cache_rdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .busy        (busy)
`ifdef NODES_CACHE_CTRL_STATS_EN
    ,
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic node_mem_t base_val(input logic [AW-1:0] a);
    return 32'hA000_0000 | {22'd0, a};
  endfunction

  // Cache behaviour: registered hit/data one cycle after a lookup.
  bit        cval [0:1023];
  node_mem_t cdat [0:1023];
  always @(posedge clk) begin
    if (cache_valid === 1'b1 && cache_write === 1'b1) begin
      cdat[cache_addr] <= cache_wdata;
      cval[cache_addr] <= 1'b1;
    end
    cache_hit   <= (cache_valid === 1'b1) && (cache_write === 1'b0) && cval[cache_addr];
    cache_rdata <= (cache_valid === 1'b1 && cache_write === 1'b0) ? cdat[cache_addr] : '0;
  end

  // Node memory: acks on the mem_lat-th cycle of a request, data combinational with ack.
  int        mem_lat = 1;
  int        mcnt;
  bit        spur_ack = 1'b0;
  bit        mw_val [0:1023];
  node_mem_t mw_dat [0:1023];
  assign mem_ack   = ((mem_req === 1'b1) && (mcnt == mem_lat - 1)) || spur_ack;
  assign mem_rdata = mw_val[mem_addr] ? mw_dat[mem_addr] : base_val(mem_addr);
  always @(posedge clk) begin
    if (rst || mem_req !== 1'b1 || mem_ack) mcnt <= 0;
    else                                    mcnt <= mcnt + 1;
    if (mem_req === 1'b1 && mem_we === 1'b1 && mem_ack) begin
      mw_dat[mem_addr] <= mem_wdata;
      mw_val[mem_addr] <= 1'b1;
    end
  end

  // Transaction-level reference: one request in flight, timeline from the latency rules.
  bit            m_busy, m_write, m_hit, m_acked, m_last_ok;
  int            m_ptr, m_id, m_gc, m_rc, m_fc, m_hits, m_misses, m_mrq;
  logic [AW-1:0] m_addr;
  node_mem_t     m_data, m_last;
  bit            ref_w [0:1023];
  node_mem_t     ref_d [0:1023];
  bit            m_cached [0:1023];

  function automatic node_mem_t ref_rd(input logic [AW-1:0] a);
    return ref_w[a] ? ref_d[a] : base_val(a);
  endfunction

  always @(negedge clk) begin : model
    int            k, g;
    logic [NR-1:0] exp_rdy;
    logic [IW-1:0] gi;
    bit            e_busy, e_mem, e_look, e_fill, e_rsp;
    if (cyc > 0) begin
      k       = cyc - m_gc;
      g       = -1;
      exp_rdy = '0;
      if (!rst && !m_busy && (req_valid != '0)) begin
        for (int i = 0; i < NR; i++) begin
          if (g < 0 && req_valid[IW'((m_ptr + i) % NR)]) g = (m_ptr + i) % NR;
        end
        exp_rdy = NR'(1) << g;
      end
      e_busy = m_busy && (k >= 1);
      e_mem  = m_busy && !m_hit && (k >= 3) && !m_acked;
      e_look = m_busy && (k == 1);
      e_fill = m_busy && m_acked && (cyc == m_fc);
      e_rsp  = m_busy && (cyc == m_rc);
      if (mem_req === 1'b1) m_mrq++;

      check("req_ready", req_ready, exp_rdy);
      check("busy", busy, e_busy);
      check("mem_req", mem_req, e_mem);
      check("mem_we", mem_we, e_mem && m_write);
      check("cache_valid", cache_valid, e_look || e_fill);
      check("cache_write", cache_write, e_fill);
      check("rsp_valid", rsp_valid, e_rsp ? (NR'(1) << m_id) : '0);
      if (e_mem) begin
        check("mem_addr", mem_addr, m_addr);
        if (m_write) check("mem_wdata", mem_wdata, m_data);
      end
      if (e_look || e_fill) check("cache_addr", cache_addr, m_addr);
      if (e_fill) check("fill_data", cache_wdata, m_write ? m_data : ref_rd(m_addr));
      if (e_rsp && !m_write) check("rsp_data", rsp_data, ref_rd(m_addr));
      else if (!e_rsp && m_last_ok) check("rsp_data_hold", rsp_data, m_last);

      if (rst) begin
        m_busy    = 1'b0;
        m_ptr     = 0;
        m_last    = '0;
        m_last_ok = 1'b1;
        m_hits    = 0;
        m_misses  = 0;
      end else if (!m_busy) begin
        if (g >= 0) begin
          gi      = IW'(g);
          m_busy  = 1'b1;
          m_id    = g;
          m_gc    = cyc;
          m_addr  = req_addr[gi];
          m_write = req_write[gi];
          m_data  = req_data[gi];
          m_hit   = !m_write && m_cached[m_addr];
          m_acked = 1'b0;
          m_rc    = m_hit ? cyc + 3 : -100;
          m_fc    = -100;
          m_ptr   = (g + 1) % NR;
        end
      end else begin
        if (e_mem && mem_ack) begin
          m_acked = 1'b1;
          m_fc    = cyc + 1;
          m_rc    = cyc + 2;
          if (m_write) begin
            ref_w[m_addr] = 1'b1;
            ref_d[m_addr] = m_data;
          end
        end
        if (e_fill) m_cached[m_addr] = 1'b1;
        if (k == 2 && !m_write) begin
          if (m_hit) m_hits++;
          else       m_misses++;
        end
        if (e_rsp) begin
          m_busy = 1'b0;
          if (!m_write) begin
            m_last    = ref_rd(m_addr);
            m_last_ok = 1'b1;
          end else begin
            m_last_ok = 1'b0;
          end
        end
        if (m_busy && k > 300) begin
          check("txn_timeout", 64'(k), 64'd300);
          m_busy = 1'b0;
        end
      end
    end
  end

  task automatic wait_ready(input int id, output int gc);
    gc = -1;
    for (int n = 0; n < 200 && gc < 0; n++) begin
      @(negedge clk);
      if (req_ready[IW'(id)]) gc = cyc;
    end
    if (gc < 0) check("grant_timeout", 64'd0, 64'(id + 1));
  endtask

  task automatic wait_any_ready(output int idx);
    idx = -1;
    for (int n = 0; n < 200 && idx < 0; n++) begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) if (req_ready[IW'(i)]) idx = i;
    end
    if (idx < 0) check("any_grant_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_rsp(input int id, output int rc, output node_mem_t d);
    rc = -1;
    d  = '0;
    for (int n = 0; n < 200 && rc < 0; n++) begin
      @(negedge clk);
      if (rsp_valid[IW'(id)]) begin
        rc = cyc;
        d  = rsp_data;
      end
    end
    if (rc < 0) check("rsp_timeout", 64'd0, 64'(id + 1));
  endtask

  task automatic run_req(input int id, input bit wr, input logic [AW-1:0] a, input node_mem_t d,
                         input int lat, output int lat_out, output node_mem_t rd);
    int gc, rc;
    mem_lat            = lat;
    req_write[IW'(id)] = wr;
    req_addr[IW'(id)]  = a;
    req_data[IW'(id)]  = d;
    req_valid[IW'(id)] = 1'b1;
    wait_ready(id, gc);
    @(posedge clk);
    #1 req_valid[IW'(id)] = 1'b0;
    wait_rsp(id, rc, rd);
    lat_out = rc - gc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int        lat, n0, idx, gc, rc;
    int        order [$];
    bit        re;
    node_mem_t rd;
    rst       = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_data  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_busy", busy, 1'b0);
    check("reset_rsp_data", rsp_data, 32'h0);
    check("reset_mem_req", mem_req, 1'b0);

    // Read miss, then the same read hits.
    n0 = m_mrq;
    run_req(0, 1'b0, 10'h025, '0, 3, lat, rd);
    check("miss_latency", 64'(lat), 64'd7);
    check("miss_data", rd, 32'hA000_0025);
    check("miss_mem_cycles", 64'(m_mrq - n0), 64'd3);
    n0 = m_mrq;
    run_req(0, 1'b0, 10'h025, '0, 3, lat, rd);
    check("hit_latency", 64'(lat), 64'd3);
    check("hit_data", rd, 32'hA000_0025);
    check("hit_no_mem", 64'(m_mrq - n0), 64'd0);

    // Stray ack while idle must be ignored.
    spur_ack = 1'b1;
    @(posedge clk);
    #1 spur_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Write-through at the top address, then read it back from the cache.
    run_req(2, 1'b1, 10'h3FF, 32'hB0B0_B0B0, 2, lat, rd);
    check("write_latency", 64'(lat), 64'd6);
    check("write_mem", mw_dat[10'h3FF], 32'hB0B0_B0B0);
    run_req(2, 1'b0, 10'h3FF, '0, 2, lat, rd);
    check("write_readback_lat", 64'(lat), 64'd3);
    check("write_readback", rd, 32'hB0B0_B0B0);

    // Write hit replaces the cached line.
    run_req(3, 1'b1, 10'h025, 32'hC0DE_0025, 1, lat, rd);
    check("write_hit_latency", 64'(lat), 64'd5);
    run_req(0, 1'b0, 10'h025, '0, 1, lat, rd);
    check("write_hit_readback", rd, 32'hC0DE_0025);

    // Round-robin with all requesters valid; req1 re-asserts after its first grant.
    do_reset();
    mem_lat = 1;
    for (int i = 0; i < NR; i++) begin
      req_write[IW'(i)] = 1'b0;
      req_addr[IW'(i)]  = AW'(i + 1);
    end
    req_valid = '1;
    re = 1'b0;
    for (int n = 0; n < 5; n++) begin
      wait_any_ready(idx);
      order.push_back(idx);
      @(posedge clk);
      #1;
      if (idx >= 0) req_valid[IW'(idx)] = 1'b0;
      if (idx == 1 && !re) begin
        re = 1'b1;
        @(posedge clk);
        #1 req_valid[1] = 1'b1;
      end
    end
    wait_rsp(1, rc, rd);
    req_valid = '0;
    check("rr_count", 64'(order.size()), 64'd5);
    if (order.size() == 5) begin
      check("rr_grant0", 64'(order[0]), 64'd0);
      check("rr_grant1", 64'(order[1]), 64'd1);
      check("rr_grant2", 64'(order[2]), 64'd2);
      check("rr_grant3", 64'(order[3]), 64'd3);
      check("rr_grant4", 64'(order[4]), 64'd1);
    end
    @(posedge clk);
    #1;

    // Memory stall of 20 cycles with competing requesters waiting.
    mem_lat      = 20;
    req_write[0] = 1'b0;
    req_addr[0]  = 10'h200;
    req_valid[0] = 1'b1;
    wait_ready(0, gc);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    req_addr[1]  = 10'h201;
    req_addr[3]  = 10'h203;
    req_write[1] = 1'b0;
    req_write[3] = 1'b0;
    req_valid[1] = 1'b1;
    req_valid[3] = 1'b1;
    wait_rsp(0, rc, rd);
    mem_lat = 1;
    check("stall_latency", 64'(rc - gc), 64'd24);
    check("stall_data", rd, 32'hA000_0200);
    wait_any_ready(idx);
    check("stall_next_grant", 64'(idx), 64'd1);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    wait_ready(3, gc);
    @(posedge clk);
    #1 req_valid[3] = 1'b0;
    wait_rsp(3, rc, rd);
    @(posedge clk);
    #1;

    // Reset while a read miss waits on memory.
    mem_lat      = 50;
    req_write[2] = 1'b0;
    req_addr[2]  = 10'h100;
    req_valid[2] = 1'b1;
    wait_ready(2, gc);
    @(posedge clk);
    #1 req_valid[2] = 1'b0;
    for (int n = 0; n < 20 && mem_req !== 1'b1; n++) @(negedge clk);
    check("abort_mem_req_seen", mem_req, 1'b1);
    repeat (4) @(negedge clk);
    do_reset();
    check("abort_mem_req", mem_req, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_rsp", rsp_valid, 4'b0000);
    mem_lat      = 1;
    req_addr[1]  = 10'h101;
    req_addr[3]  = 10'h102;
    req_valid[1] = 1'b1;
    req_valid[3] = 1'b1;
    wait_any_ready(idx);
    check("abort_ptr_cleared", 64'(idx), 64'd1);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    wait_ready(3, gc);
    @(posedge clk);
    #1 req_valid[3] = 1'b0;
    wait_rsp(3, rc, rd);
    @(posedge clk);
    #1;

    // Fresh counters: 2 read misses, 3 read hits, 1 write.
    do_reset();
    run_req(0, 1'b0, 10'h050, '0, 1, lat, rd);
    run_req(1, 1'b0, 10'h051, '0, 1, lat, rd);
    run_req(2, 1'b0, 10'h050, '0, 1, lat, rd);
    run_req(3, 1'b0, 10'h051, '0, 1, lat, rd);
    run_req(0, 1'b1, 10'h052, 32'h1234_5678, 1, lat, rd);
    run_req(1, 1'b0, 10'h050, '0, 1, lat, rd);
    check("seg_hits_model", 64'(m_hits), 64'd3);
    check("seg_misses_model", 64'(m_misses), 64'd2);
`ifdef NODES_CACHE_CTRL_STATS_EN
    check("stat_hits", stat_hits, 16'd3);
    check("stat_misses", stat_misses, 16'd2);
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
